// File: rtl/phase_align_pkg.sv
// Shared types and helpers for the phase alignment loop.
// Maps a single detected data edge to a bang-bang vote.
package phase_align_pkg;

   localparam int NUM_PHASES = 4;
   localparam int PH_W = $clog2(NUM_PHASES);

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      EARLY = 2'd1,
      LATE  = 2'd2
   } vote_t;

   // Vote toward the phase opposite the edge; ambiguous edges vote NONE.
   function automatic vote_t edge_to_vote(
      input logic [3:0]      edges,
      input logic [PH_W-1:0] ctrl
   );
      logic [PH_W-1:0] k;
      logic [PH_W-1:0] d;
      logic [PH_W-1:0] diff;
      logic            one;
      vote_t           v;
      k   = '0;
      one = 1'b1;
      v   = NONE;
      unique case (edges)
         4'b0001: k = 2'd0;
         4'b0010: k = 2'd1;
         4'b0100: k = 2'd2;
         4'b1000: k = 2'd3;
         default: one = 1'b0;
      endcase
      d    = k + 2'd2;
      diff = d - ctrl;
      if (one && diff == 2'd1)
         v = LATE;
      else if (one && diff == 2'd3)
         v = EARLY;
      return v;
   endfunction

endpackage

// File: rtl/phase_edge_detect.sv
// Edge locator: finds the data transition among four phase samples
// and registers the resulting vote against the current phase select.
module phase_edge_detect
   import phase_align_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      samples,
   input  logic            sample_valid,
   input  logic [PH_W-1:0] control,
   output vote_t           vote_q,
   output logic            vote_valid
);

   logic       s3_prev;
   logic [3:0] edges;

   // Transition between each adjacent pair, phase 0 against last UI's phase 3.
   always_comb begin
      edges = {samples[2] ^ samples[3],
               samples[1] ^ samples[2],
               samples[0] ^ samples[1],
               s3_prev    ^ samples[0]};
   end

   // Register vote; invalid cycles produce NONE and keep s3_prev.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_prev    <= 1'b0;
         vote_q     <= NONE;
         vote_valid <= 1'b0;
      end else begin
         vote_valid <= sample_valid;
         if (sample_valid) begin
            s3_prev <= samples[3];
            vote_q  <= edge_to_vote(edges, control);
         end else begin
            vote_q  <= NONE;
         end
      end
   end

endmodule

// File: rtl/phase_align_ctrl.sv
// Bang-bang phase alignment loop: filters edge votes and steps the
// four-phase select word, reporting lock once the loop stops stepping.
module phase_align_ctrl
   import phase_align_pkg::*;
#(
   parameter int THRESH     = 8,
   parameter int ACC_W      = 5,
   parameter int LOCK_CNT   = 16,
   parameter int INIT_PHASE = 0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic [3:0]      samples,
   input  logic            sample_valid,
   input  logic            force_load,
   input  logic [PH_W-1:0] force_phase,
   output logic [PH_W-1:0] control,
   output logic            locked,
   output logic            step_up,
   output logic            step_dn
);

   localparam int CNT_W = $clog2(LOCK_CNT + 1);
   localparam logic signed [ACC_W-1:0] POS_T = ACC_W'(THRESH);
   localparam logic signed [ACC_W-1:0] NEG_T = -POS_T;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);
   localparam logic [PH_W-1:0] INIT_CTRL = PH_W'(INIT_PHASE);

   vote_t                   vote_q;
   logic                    vote_valid;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] vote_val;
   logic [CNT_W-1:0]        lock_cnt;
   logic                    up;
   logic                    dn;

   phase_edge_detect u_edge (
      .clk          (clk),
      .rst          (rst),
      .samples      (samples),
      .sample_valid (sample_valid),
      .control      (control),
      .vote_q       (vote_q),
      .vote_valid   (vote_valid)
   );

   // Loop filter: integrate votes and flag a threshold crossing.
   always_comb begin
      vote_val = '0;
      unique case (vote_q)
         LATE:    vote_val = ACC_W'(1);
         EARLY:   vote_val = '1;
         default: vote_val = '0;
      endcase
      acc_next = acc + vote_val;
      up = enable && (acc_next >= POS_T);
      dn = enable && (acc_next <= NEG_T);
   end

   // Phase select, accumulator and lock counter; force_load wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         control  <= INIT_CTRL;
         acc      <= '0;
         lock_cnt <= '0;
         step_up  <= 1'b0;
         step_dn  <= 1'b0;
      end else if (force_load) begin
         control  <= force_phase;
         acc      <= '0;
         lock_cnt <= '0;
         step_up  <= 1'b0;
         step_dn  <= 1'b0;
      end else begin
         step_up <= up;
         step_dn <= dn;
         if (up) begin
            control  <= control + PH_W'(1);
            acc      <= '0;
            lock_cnt <= '0;
         end else if (dn) begin
            control  <= control - PH_W'(1);
            acc      <= '0;
            lock_cnt <= '0;
         end else if (enable) begin
            acc <= acc_next;
            if (vote_valid && lock_cnt != CNT_MAX)
               lock_cnt <= lock_cnt + CNT_W'(1);
         end
      end
   end

   assign locked = (lock_cnt == CNT_MAX);

endmodule

// File: doc/phase_align_ctrl.md
Name: phase_align_ctrl

Overview:
- Closed-loop controller that generates the 2-bit `control` word for the four-phase selector.
- Inputs are data samples taken on all four clock phases, already retimed into `clk`. From these it finds where the data edge falls within the UI, runs a filtered bang-bang vote and steps the selected phase so sampling sits opposite the edge.
- Sits between the four-phase sampler and the phase selector in the GBX receive path; reports lock status.

Parameters:
- THRESH, 8: vote magnitude at which `control` steps; range 2..(2^(ACC_W-1))-1.
- ACC_W, 5: signed accumulator width.
- LOCK_CNT, 16: consecutive valid cycles without a step before `locked` asserts.
- INIT_PHASE, 0: `control` value after reset; range 0..3.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: tracking enable. When 0, votes are discarded, accumulator and lock counter hold, `control` holds.
- `samples`, input, 4: data sampled at phases 0..3 for the current UI. Bit i = phase i.
- `sample_valid`, input, 1: `samples` is valid this cycle.
- `force_load`, input, 1: synchronous override of `control`.
- `force_phase`, input, 2: value loaded by `force_load`.
- `control`, output, 2: phase select word to the selector.
- `locked`, output, 1: loop settled.
- `step_up`, output, 1: one-cycle pulse when `control` increments.
- `step_dn`, output, 1: one-cycle pulse when `control` decrements.

Behaviour:
- Reset (async, while `rst`=1):
  - `control`=INIT_PHASE; `locked`=0; `step_up`=0; `step_dn`=0.
  - Accumulator=0; lock counter=0; `vote_q`=NONE; `s3_prev`=0.
  - `rst` asserted mid-operation aborts immediately. No residual step is produced after release.
- Stage 1, edge detect (registered):
  - On each `sample_valid`, compute e0=`s3_prev`^s[0], e1=s[0]^s[1], e2=s[1]^s[2], e3=s[2]^s[3].
  - `s3_prev` updates to s[3] only on valid cycles.
  - Exactly one e_k set: edge index k; desired phase d=(k+2) mod 4; diff=(d-`control`) mod 4.
  - diff=1 gives LATE (+1). diff=3 gives EARLY (-1). diff=0 or 2 gives NONE.
  - Zero or more than one e_k set gives NONE.
  - `vote_q` is registered. A non-valid cycle yields NONE.
- Stage 2, filter (acts on `vote_q`, only when `enable`=1):
  - acc_next = acc + vote.
  - If acc_next >= THRESH: `control`+1 mod 4 (3 wraps to 0), acc=0, `step_up` pulses.
  - If acc_next <= -THRESH: `control`-1 mod 4 (0 wraps to 3), acc=0, `step_dn` pulses.
  - Otherwise acc=acc_next. Arithmetic is signed ACC_W; no overflow is possible because of the THRESH bound.
- Latency: samples valid in cycle n, vote registered at end of n, `control` updates at end of n+1.
- Stage 1 compares against `control` as registered at cycle n. A vote in flight during a step is still applied to the cleared accumulator; this is accepted.
- Lock:
  - Lock counter increments on each cycle with `vote_q` from a valid sample and no step, saturating at LOCK_CNT.
  - `locked`=1 when the counter equals LOCK_CNT.
  - Any step or `force_load` clears the counter and `locked` on that edge.
  - Lock state is not modified while `enable`=0.
- `force_load` has highest priority:
  - `control`=`force_phase`, acc=0, lock counter=0, `locked`=0, no step pulse.
  - This applies even when a threshold crossing coincides in the same cycle.
- `step_up` and `step_dn` are mutually exclusive, registered, and last one cycle.

Decomposition:
- Package `phase_align_pkg` holds:
  - `vote_t` enum (NONE, EARLY, LATE);
  - a function `edge_to_vote`(edges[3:0], ctrl[1:0]);
  - the constant NUM_PHASES=4.
- One sub-module, `phase_edge_detect`: stage 1 (`s3_prev`, edge vector, `vote_q`). The filter, lock logic and `control` register stay in the top.

Test Plan:
- Late pull-in: reset INIT_PHASE=0, `enable`=1; alternate `samples` 4'b1000/4'b0111 every cycle (k=3) -> 8 LATE votes; `step_up` pulses once; `control`=1 two cycles after the 8th valid sample; then 16 more valid cycles -> `locked`=1.
- Early with wrap: INIT_PHASE=0; alternate 4'b1110/4'b0001 (k=1, d=3) -> after 8 votes `step_dn` pulses and `control`=3; further votes are NONE (diff=0); `locked`=1 after 16 cycles.
- Ambiguous data:
  - 4'b0101 every cycle (multiple edges) -> no votes, `control` held, `locked` asserts after 16 valid cycles.
  - Constant 4'b0000 (no edges) -> same result.
- Gating:
  - Late pattern with `sample_valid` toggling every other cycle -> step after 8 valid samples (16 cycles).
  - `enable`=0 for 20 cycles -> no change to `control`, accumulator or `locked`.
- Force override: locked at `control`=1; `force_load`=1, `force_phase`=2 in the same cycle as the 8th LATE vote -> `control`=2, no `step_up`, `locked`=0 next cycle.
- Reset mid-operation: after 5 LATE votes assert `rst` asynchronously -> `control`=INIT_PHASE and `locked`=0 immediately; after release, 8 fresh votes are needed for a step.
